// File: rtl/frame_fetch_pkg.sv
// -----------------------------------------------------------------------------
// frame_fetch_pkg
// Shared constants, the fetch FSM state type and the pixel-unpack helper used by
// the frame fetcher and its memory-bus interface.
//   PIX_PER_WORD  pixels carried by one 256-bit memory word
//   SLOT_W        bits per pixel slot (the top byte of each slot is padding)
//   ADDR_W/DATA_W memory word address / data widths
// -----------------------------------------------------------------------------
package frame_fetch_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int SLOT_W       = 32;
  localparam int ADDR_W       = 28;
  localparam int DATA_W       = PIX_PER_WORD * SLOT_W;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Select slot idx of a word; slot k occupies bits [32k+23:32k] as {r,g,b}.
  function automatic pixel_t unpack_slot(input logic [DATA_W-1:0] word,
                                         input logic [IDX_W-1:0]  idx);
    pixel_t p;
    p = '0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (idx == IDX_W'(k)) p = word[k*SLOT_W +: 24];
    end
    return p;
  endfunction

endpackage

// File: rtl/frame_fetch_if.sv
// -----------------------------------------------------------------------------
// frame_fetch_if
// Memory-controller read port used by the frame fetcher.
//   mem_valid_data   request valid (fetcher -> memory)
//   mem_rw_data      0 = read
//   mem_data_addr    word address of the request
//   data_wr          write data (unused by a reader, driven 0)
//   last_addr_update pulse when the last word of the frame is accepted
//   mem_ready_data   request accepted, data_rd valid this cycle (memory -> fetcher)
//   data_rd          read data
// Modports: master = fetcher side, slave = memory side.
// -----------------------------------------------------------------------------
interface frame_fetch_if;
  import frame_fetch_pkg::*;

  logic              mem_valid_data;
  logic              mem_rw_data;
  logic [ADDR_W-1:0] mem_data_addr;
  logic [DATA_W-1:0] data_wr;
  logic              last_addr_update;
  logic              mem_ready_data;
  logic [DATA_W-1:0] data_rd;

  modport master (
    output mem_valid_data, mem_rw_data, mem_data_addr, data_wr, last_addr_update,
    input  mem_ready_data, data_rd
  );

  modport slave (
    input  mem_valid_data, mem_rw_data, mem_data_addr, data_wr, last_addr_update,
    output mem_ready_data, data_rd
  );

endinterface

// File: rtl/frame_fetch_word_fifo.sv
// -----------------------------------------------------------------------------
// fetch_word_fifo
// Synchronous DEPTH x WIDTH word FIFO with a show-ahead output: dout always
// presents the oldest entry so the consumer can load it in the same cycle it
// pops. The array is tiny, so the combinational read maps to distributed RAM.
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   wr_en, din  push a word (caller guarantees not full)
//   rd_en       pop the oldest word (caller guarantees not empty)
//   dout        oldest word
//   count       number of stored words (0..DEPTH)
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module fetch_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/frame_fetch.sv
// -----------------------------------------------------------------------------
// frame_fetch
// Reads a frame from memory as 256-bit words (one request outstanding at a
// time), buffers them in a small word FIFO and unpacks each word into 8 pixels
// presented as a first-word-fall-through stream to the VGA timing logic.
// Ports:
//   Clk, Reset_n      pixel clock, asynchronous active-low reset
//   start             level; fetching runs while high
//   mem               frame_fetch_if.master memory read port
//   rd_fifo           consume head pixel
//   fifo_empty        no head pixel available
//   pixel_r/g/b       head pixel (holds last value while empty)
//   underflow_cnt     [FRAME_FETCH_UNDERFLOW_CNT_EN only] saturating count of
//                     cycles with rd_fifo while fifo_empty
// Build option: define FRAME_FETCH_UNDERFLOW_CNT_EN to add underflow_cnt.
// -----------------------------------------------------------------------------
module frame_fetch
  import frame_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 28'h0000000,
  parameter int                FRAME_WORDS = 38400,
  parameter int                WORD_DEPTH  = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  frame_fetch_if.master      mem,
  input  logic               rd_fifo,
  output logic               fifo_empty,
`ifdef FRAME_FETCH_UNDERFLOW_CNT_EN
  output logic [15:0]        underflow_cnt,
`endif
  output logic [7:0]         pixel_r,
  output logic [7:0]         pixel_g,
  output logic [7:0]         pixel_b
);

  localparam int                CNT_W     = $clog2(WORD_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PIX_PER_WORD - 1);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              req_valid;
  logic              accept;

  logic [DATA_W-1:0] head_word_reg;
  logic              head_valid_reg;
  logic [IDX_W-1:0]  idx_reg;

  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_has_word;
  logic              has_free;
  logic              pop;
  logic              head_need;
  logic              fifo_rd_en;
  logic              fifo_wr_en;
  logic              bypass;
  pixel_t            head_pix;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  assign has_free = (fifo_count < CNT_W'(WORD_DEPTH));
  assign accept   = req_valid & mem.mem_ready_data;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_WAIT;
      ST_WAIT: begin
        // A dropped start only takes effect between requests.
        if (!start)        state_next = ST_IDLE;
        else if (has_free) state_next = ST_REQ;
      end
      ST_REQ: begin
        req_valid = 1'b1;
        if (mem.mem_ready_data) state_next = ST_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_reg <= BASE_ADDR;
    end else if (accept) begin
      addr_reg <= (addr_reg == LAST_ADDR) ? BASE_ADDR : addr_reg + ADDR_W'(1);
    end
  end

  assign mem.mem_valid_data   = req_valid;
  assign mem.mem_rw_data      = 1'b0;
  assign mem.data_wr          = '0;
  assign mem.mem_data_addr    = addr_reg;
  assign mem.last_addr_update = accept & (addr_reg == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // Word FIFO and head register
  // ---------------------------------------------------------------------------
  // The head needs a new word when it is empty or its last pixel is popped now.
  // The FIFO is drained first; only when it is empty does an arriving word skip
  // it and land in the head directly. Head invalid implies FIFO empty, so the
  // bypass never reorders words.
  assign fifo_has_word = (fifo_count != '0);
  assign pop           = rd_fifo & head_valid_reg;
  assign head_need     = !head_valid_reg | (pop & (idx_reg == LAST_IDX));
  assign fifo_rd_en    = head_need & fifo_has_word;
  assign bypass        = head_need & !fifo_has_word & accept;
  assign fifo_wr_en    = accept & !bypass;

  fetch_word_fifo #(
    .DEPTH (WORD_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_word_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .wr_en (fifo_wr_en),
    .din   (mem.data_rd),
    .rd_en (fifo_rd_en),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // On going empty the word and index are left alone so the outputs hold the
  // last pixel shown.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_word_reg  <= '0;
      head_valid_reg <= 1'b0;
      idx_reg        <= '0;
    end else if (fifo_rd_en) begin
      head_word_reg  <= fifo_dout;
      head_valid_reg <= 1'b1;
      idx_reg        <= '0;
    end else if (bypass) begin
      head_word_reg  <= mem.data_rd;
      head_valid_reg <= 1'b1;
      idx_reg        <= '0;
    end else if (pop) begin
      if (idx_reg == LAST_IDX) head_valid_reg <= 1'b0;
      else                     idx_reg        <= idx_reg + IDX_W'(1);
    end
  end

  assign head_pix   = unpack_slot(head_word_reg, idx_reg);
  assign pixel_r    = head_pix.r;
  assign pixel_g    = head_pix.g;
  assign pixel_b    = head_pix.b;
  assign fifo_empty = !head_valid_reg;

  // ---------------------------------------------------------------------------
  // Underflow monitor
  // ---------------------------------------------------------------------------
`ifdef FRAME_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      underflow_cnt_reg <= '0;
    end else if (rd_fifo && !head_valid_reg && (underflow_cnt_reg != 16'hFFFF)) begin
      underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
    end
  end

  assign underflow_cnt = underflow_cnt_reg;
`else
  // No monitor: rd_fifo with an empty head is simply a no-op in the head logic.
`endif

endmodule

// File: tb/tb_frame_fetch.sv
// -----------------------------------------------------------------------------
// tb_frame_fetch
// Directed bench for frame_fetch (FRAME_WORDS overridden to 4 so address wrap
// is reached quickly). A memory responder answers requests with words whose
// slot k is {8'hEE, k, k+1, n} (n = word sequence number), and a pixel consumer
// checks every popped pixel against r=k, g=k+1, b=n. Optional underflow_cnt is
// checked when FRAME_FETCH_UNDERFLOW_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_frame_fetch;
  import frame_fetch_pkg::*;

  localparam int FRAME_WORDS = 4;
  localparam int WORD_DEPTH  = 4;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       rd_fifo = 1'b0;
  logic       fifo_empty;
  logic [7:0] pixel_r, pixel_g, pixel_b;
`ifdef FRAME_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  frame_fetch_if mem_if ();

  frame_fetch #(
    .BASE_ADDR   (28'h0000000),
    .FRAME_WORDS (FRAME_WORDS),
    .WORD_DEPTH  (WORD_DEPTH)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .mem           (mem_if),
    .rd_fifo       (rd_fifo),
    .fifo_empty    (fifo_empty),
`ifdef FRAME_FETCH_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .pixel_r       (pixel_r),
    .pixel_g       (pixel_g),
    .pixel_b       (pixel_b)
  );

  always #20 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] make_word(input int n);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = {8'hEE, 8'(k), 8'(k + 1), 8'(n)};
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder: ready mem_lat cycles into a request, one line per word
  // ---------------------------------------------------------------------------
  bit          resp_en  = 1'b1;
  int          mem_lat  = 0;
  int          wait_cnt = 0;
  int          seq      = 0;
  logic [27:0] addr_log [256];
  logic        last_log [256];

  initial begin
    mem_if.mem_ready_data = 1'b0;
    mem_if.data_rd        = '0;
    forever begin
      @(negedge Clk);
      mem_if.mem_ready_data = 1'b0;
      if (!Reset_n || !resp_en || !mem_if.mem_valid_data) begin
        wait_cnt = 0;
      end else if (wait_cnt < mem_lat) begin
        wait_cnt++;
      end else begin
        mem_if.mem_ready_data = 1'b1;
        mem_if.data_rd        = make_word(seq);
        #1;
        if (seq < 256) begin
          addr_log[seq] = mem_if.mem_data_addr;
          last_log[seq] = mem_if.last_addr_update;
        end
        $display("mem word %0d addr=%0h last=%0b", seq, mem_if.mem_data_addr,
                 mem_if.last_addr_update);
        seq++;
        wait_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel consumer: every pop is checked against the expected stream
  // ---------------------------------------------------------------------------
  int pix_seq = 0;
  int uf_exp  = 0;

  initial begin
    forever begin
      @(negedge Clk);
      if (Reset_n && rd_fifo) begin
        if (fifo_empty) begin
          uf_exp++;
        end else begin
          check("pixel", {8'h0, pixel_r, pixel_g, pixel_b},
                {8'h0, 8'(pix_seq % 8), 8'(pix_seq % 8 + 1), 8'(pix_seq / 8)});
          pix_seq++;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int got;
  int empties;

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_valid", mem_if.mem_valid_data, 0);
    check("rst_addr", mem_if.mem_data_addr, 0);
    check("rst_last", mem_if.last_addr_update, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_pixel", {8'h0, pixel_r, pixel_g, pixel_b}, 0);
    check("rw_wr_zero", {31'b0, mem_if.mem_rw_data | (|mem_if.data_wr)}, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check("idle_no_start", mem_if.mem_valid_data, 0);

    // First word latency and streaming with wrap
    mem_lat = 1;
    start   = 1'b1;
    got     = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge Clk); #2;
      if (mem_if.mem_ready_data) got = 1;
    end
    check("t1_first_ready_seen", got, 1);
    check("t1_empty_before", fifo_empty, 1);
    @(posedge Clk); #1;
    check("t1_empty_after", fifo_empty, 0);
    check("t1_head_pixel", {8'h0, pixel_r, pixel_g, pixel_b}, 32'h0000_0100);
    rd_fifo = 1'b1;
    repeat (100) @(posedge Clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      check("t2_addr", addr_log[i], i % FRAME_WORDS);
      check("t2_last", last_log[i], (i % FRAME_WORDS) == FRAME_WORDS - 1);
    end

    // Asynchronous reset during an open request
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(posedge Clk); #1;
      if (mem_if.mem_valid_data) got = 1;
    end
    check("t5_valid_seen", got, 1);
    #5;
    Reset_n = 1'b0;
    mem_if.mem_ready_data = 1'b0;
    rd_fifo = 1'b0;
    #1;
    check("t5_valid_drop", mem_if.mem_valid_data, 0);
    check("t5_empty", fifo_empty, 1);
    check("t5_addr", mem_if.mem_data_addr, 0);
    check("t5_last", mem_if.last_addr_update, 0);
    seq     = 0;
    pix_seq = 0;
    uf_exp  = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // No consumer: FIFO plus head fill, then requests stop
    mem_lat = 0;
    repeat (60) @(posedge Clk);
    #1;
    check("t3_requests", seq, WORD_DEPTH + 1);
    check("t3_valid_idle", mem_if.mem_valid_data, 0);
    for (int i = 0; i < WORD_DEPTH + 1; i++) check("t3_addr", addr_log[i], i % FRAME_WORDS);
    check("t3_last3", last_log[3], 1);
    check("t3_last4", last_log[4], 0);
    check("t3_next_addr", mem_if.mem_data_addr, 1);
    check("t3_empty", fifo_empty, 0);
    check("t3_head_pixel", {8'h0, pixel_r, pixel_g, pixel_b}, 32'h0000_0100);

    // Drain with memory stalled: exactly 40 pixels, then underflow
    resp_en = 1'b0;
    rd_fifo = 1'b1;
    repeat (60) @(posedge Clk);
    #1;
    rd_fifo = 1'b0;
    @(posedge Clk); #1;
    check("t4_pixels", pix_seq, 8 * (WORD_DEPTH + 1));
    check("t4_empty", fifo_empty, 1);
    check("t4_stalled_req", mem_if.mem_valid_data, 1);
    check("t4_hold_pixel", {8'h0, pixel_r, pixel_g, pixel_b}, 32'h0007_0804);
`ifdef FRAME_FETCH_UNDERFLOW_CNT_EN
    check("t4_underflow_cnt", underflow_cnt, uf_exp);
    check("t4_underflow_20", underflow_cnt, 20);
`endif

    // Back-to-back answers, continuous consumption
    resp_en = 1'b1;
    rd_fifo = 1'b1;
    repeat (30) @(posedge Clk);
    empties = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1;
      if (fifo_empty) empties++;
    end
    rd_fifo = 1'b0;
    @(posedge Clk); #1;
    check("t6_no_bubble", empties, 0);
    check("t6_progress", (pix_seq >= 150) ? 1 : 0, 1);
    check("t6_addr_wrap", addr_log[seq - 1], (seq - 1) % FRAME_WORDS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
